// File: rtl/debounce_fsm.sv
// Switch debouncer: synchronizes sw, then requires STABLE_TICKS consecutive tics of a stable level before db_level follows.
// Latency: 2 sync cycles + 1 WAIT entry cycle + STABLE_TICKS counted tics; no backpressure, outputs are registered pulses/levels.
module debounce_fsm #(
    parameter int STABLE_TICKS = 3,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tic,
    input  logic             sw,
    input  logic             clr_count,
    output logic             db_level,
    output logic             db_rise,
    output logic             db_fall,
    output logic [CNT_W-1:0] press_count
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [7:0]       K_LAST  = 8'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       k_q, k_d;
    logic             sw_meta_q, sw_meta_d;
    logic             sw_s_q, sw_s_d;
    logic             db_level_q, db_level_d;
    logic             db_rise_q, db_rise_d;
    logic             db_fall_q, db_fall_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;

    always_comb begin
        sw_meta_d = sw;
        sw_s_d    = sw_meta_q;
    end

    // The level check in each WAIT state wins over tic, so a bounce aborts even on a tic cycle.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            ZERO: begin
                if (sw_s_q) begin
                    state_d = WAIT1;
                    k_d     = 8'd0;
                end
            end
            WAIT1: begin
                if (!sw_s_q) begin
                    state_d = ZERO;
                end else if (tic) begin
                    if (k_q == K_LAST) begin
                        state_d = ONE;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            ONE: begin
                if (!sw_s_q) begin
                    state_d = WAIT0;
                    k_d     = 8'd0;
                end
            end
            WAIT0: begin
                if (sw_s_q) begin
                    state_d = ONE;
                end else if (tic) begin
                    if (k_q == K_LAST) begin
                        state_d = ZERO;
                    end else begin
                        k_d = k_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ZERO;
                k_d     = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        db_level_d = (state_d == ONE) || (state_d == WAIT0);
        db_rise_d  = (state_q == WAIT1) && (state_d == ONE);
        db_fall_d  = (state_q == WAIT0) && (state_d == ZERO);
    end

    always_comb begin
        press_count_d = press_count_q;
        if (clr_count) begin
            press_count_d = '0;
        end else if (db_rise_q && (press_count_q != CNT_MAX)) begin
            press_count_d = press_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ZERO;
            k_q           <= 8'd0;
            sw_meta_q     <= 1'b0;
            sw_s_q        <= 1'b0;
            db_level_q    <= 1'b0;
            db_rise_q     <= 1'b0;
            db_fall_q     <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            sw_meta_q     <= sw_meta_d;
            sw_s_q        <= sw_s_d;
            db_level_q    <= db_level_d;
            db_rise_q     <= db_rise_d;
            db_fall_q     <= db_fall_d;
            press_count_q <= press_count_d;
        end
    end

    assign db_level    = db_level_q;
    assign db_rise     = db_rise_q;
    assign db_fall     = db_fall_q;
    assign press_count = press_count_q;

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm with STABLE_TICKS=3, CNT_W=8; tic every 4th cycle unless overridden.
module tb_debounce_fsm;

    logic       clk;
    logic       rst_n;
    logic       tic;
    logic       sw;
    logic       clr_count;
    logic       db_level;
    logic       db_rise;
    logic       db_fall;
    logic [7:0] press_count;

    int n_checks = 0;
    int n_fail   = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int both_cnt = 0;
    int tic_mode = 0;   // 0: every 4th cycle, 1: tied high, 2: driven by tasks
    int cyc      = 0;

    debounce_fsm #(
        .STABLE_TICKS(3),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tic        (tic),
        .sw         (sw),
        .clr_count  (clr_count),
        .db_level   (db_level),
        .db_rise    (db_rise),
        .db_fall    (db_fall),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (tic_mode == 0) tic = (cyc % 4 == 0);
            else if (tic_mode == 1) tic = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (db_rise) rise_cnt = rise_cnt + 1;
        if (db_fall) fall_cnt = fall_cnt + 1;
        if (db_rise && db_fall) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_evt(input bit want_fall, input int max, output bit found, output int n);
        found = 1'b0;
        n     = 0;
        while (!found && n < max) begin
            @(negedge clk);
            n = n + 1;
            if (want_fall ? db_fall : db_rise) found = 1'b1;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tic_pulse();
        @(posedge clk);
        #1 tic = 1'b1;
        @(posedge clk);
        #1 tic = 1'b0;
    endtask

    initial begin
        bit found;
        int n;
        int timeouts;
        int r0;

        rst_n     = 1'b0;
        tic       = 1'b0;
        sw        = 1'b0;
        clr_count = 1'b0;
        #1;
        check("rst_level", db_level, 0);
        check("rst_rise", db_rise, 0);
        check("rst_fall", db_fall, 0);
        check("rst_count", press_count, 0);
        #20 rst_n = 1'b1;
        cycles(3);

        // short glitch: at most one tic while waiting, so no change
        sw = 1'b1;
        cycles(5);
        sw = 1'b0;
        cycles(20);
        check("abort_rise_cnt", rise_cnt, 0);
        check("abort_level", db_level, 0);

        // clean press
        sw = 1'b1;
        wait_evt(1'b0, 40, found, n);
        check("press_found", found, 1);
        check("press_level", db_level, 1);
        @(negedge clk);
        check("press_rise_one_cycle", db_rise, 0);
        check("press_count_1", press_count, 1);
        cycles(20);
        check("press_rise_cnt", rise_cnt, 1);

        // release
        sw = 1'b0;
        wait_evt(1'b1, 40, found, n);
        check("release_found", found, 1);
        check("release_level", db_level, 0);
        @(negedge clk);
        check("release_fall_one_cycle", db_fall, 0);
        check("release_count", press_count, 1);
        check("release_fall_cnt", fall_cnt, 1);

        // clear, then bounce for 40 cycles before holding high
        @(posedge clk);
        #1 clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        check("clr_count", press_count, 0);
        r0 = rise_cnt;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) sw = ~sw;
            @(posedge clk);
            #1;
        end
        check("bounce_no_rise", rise_cnt, r0);
        sw = 1'b1;
        wait_evt(1'b0, 40, found, n);
        check("bounce_found", found, 1);
        cycles(20);
        check("bounce_rise_cnt", rise_cnt, r0 + 1);
        check("bounce_count", press_count, 1);
        sw = 1'b0;
        wait_evt(1'b1, 40, found, n);
        check("bounce_release", found, 1);

        // reset in WAIT1 after two counted tics
        tic_mode = 2;
        tic      = 1'b0;
        cycles(2);
        sw = 1'b1;
        cycles(4);
        tic_pulse();
        tic_pulse();
        check("mid_level_before_rst", db_level, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_level", db_level, 0);
        check("mid_rst_count", press_count, 0);
        #10 rst_n = 1'b1;
        cycles(4);
        tic_pulse();
        tic_pulse();
        check("post_rst_2tics_level", db_level, 0);
        check("post_rst_2tics_rise", db_rise, 0);
        tic_pulse();
        check("post_rst_3tics_rise", db_rise, 1);
        check("post_rst_3tics_level", db_level, 1);

        // tic tied high: rise exactly 6 cycles after sw change
        tic_mode = 1;
        sw       = 1'b0;
        wait_evt(1'b1, 20, found, n);
        check("tichigh_fall_found", found, 1);
        @(posedge clk);
        #1 sw = 1'b1;
        n     = 0;
        found = 1'b0;
        while (!found && n < 20) begin
            @(posedge clk);
            n = n + 1;
            @(negedge clk);
            if (db_rise) found = 1'b1;
        end
        check("tichigh_found", found, 1);
        check("tichigh_latency", n, 6);
        sw = 1'b0;
        wait_evt(1'b1, 20, found, n);

        // saturation
        @(posedge clk);
        #1 clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        timeouts = 0;
        for (int i = 0; i < 260; i++) begin
            sw = 1'b1;
            wait_evt(1'b0, 20, found, n);
            if (!found) timeouts = timeouts + 1;
            @(negedge clk);
            if (i == 254) check("sat_at_255", press_count, 255);
            sw = 1'b0;
            wait_evt(1'b1, 20, found, n);
            if (!found) timeouts = timeouts + 1;
        end
        check("sat_timeouts", timeouts, 0);
        check("sat_count", press_count, 255);

        // clear in the db_rise cycle wins over the increment
        sw = 1'b1;
        wait_evt(1'b0, 20, found, n);
        check("clr_rise_found", found, 1);
        clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        check("clr_on_rise", press_count, 0);
        cycles(3);
        check("clr_on_rise_hold", press_count, 0);

        check("rise_fall_overlap", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
